// File: rtl/dmem_responder_pkg.sv
// Shared data-bus constants for the dmem responder.
// SIZE encodings, FSM states and the latched request bundle.
package dmem_responder_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] dad;
    logic [1:0]  size;
    logic        write;
  } req_t;

  function automatic logic is_misaligned(
    input logic [1:0] lo,
    input logic [1:0] size
  );
    logic r;
    unique case (size)
      SIZE_HALF: r = lo[0];
      SIZE_BYTE: r = 1'b0;
      default:   r = |lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/acknowledge side of the data bus.
// DDT stays a plain inout net on the responder.
interface dmem_responder_if;

  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] DAD;
  logic        ACKD_n;

  modport master (
    output MREQ,
    output WRITE,
    output SIZE,
    output DAD,
    input  ACKD_n
  );

  modport slave (
    input  MREQ,
    input  WRITE,
    input  SIZE,
    input  DAD,
    output ACKD_n
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the RAM word and the DDT bus.
// Reads are right-aligned and zero-extended; writes merge lanes.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword
);

  logic        w_byte;
  logic        w_half;
  logic [31:0] w_lanes;

  assign w_byte = (i_size == SIZE_BYTE);
  assign w_half = (i_size == SIZE_HALF);

  always_comb begin
    o_rdata = i_word;
    o_be    = 4'hF;
    w_lanes = i_wdata;
    unique case (1'b1)
      w_byte: begin
        o_rdata = {24'd0, i_word[8*i_addr +: 8]};
        o_be    = 4'b0001 << i_addr;
        w_lanes = {4{i_wdata[7:0]}};
      end
      w_half: begin
        o_rdata = {16'd0,
                   i_addr[1] ? i_word[31:16]
                             : i_word[15:0]};
        o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_lanes = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
    o_wword = i_word;
    for (int i = 0; i < 4; i++) begin
      if (o_be[i])
        o_wword[8*i +: 8] = w_lanes[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: little-endian RAM answering each request
// after WAIT_STATES cycles with a one-cycle active-low ACKD_n.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic         clk,
  input  logic         rst,
  dmem_responder_if.slave bus,
  inout  wire  [31:0]  DDT,
  output logic         misalign_err
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  req_t        r_req;
  req_t        w_req_nxt;
  logic        r_err;
  logic        w_err_nxt;

  logic [31:0] r_mem [2**ADDR_BITS];

  logic [ADDR_BITS-1:0] w_idx;
  logic [31:0] w_word;
  logic [31:0] w_rdata;
  logic [31:0] w_wword;
  logic [3:0]  w_be;
  logic        w_ddt_oe;
  logic        w_commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_req   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_err_nxt   = r_err;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.MREQ) begin
          w_req_nxt.dad   = bus.DAD;
          w_req_nxt.size  = bus.SIZE;
          w_req_nxt.write = bus.WRITE;
          w_cnt_nxt       = WS;
          w_err_nxt       = r_err |
            is_misaligned(bus.DAD[1:0], bus.SIZE);
          w_state_nxt     = (WS != 4'd0) ? ST_WAIT
                                         : ST_ACK;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1)
          w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.ACKD_n   = (r_state != ST_ACK);
  assign misalign_err = r_err;

  assign w_idx    = r_req.dad[ADDR_BITS+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_ddt_oe = (r_state == ST_ACK) && !r_req.write;
  assign w_commit = (r_state == ST_ACK) && r_req.write;

  dmem_lane_align u_align (
    .i_addr  (r_req.dad[1:0]),
    .i_size  (r_req.size),
    .i_word  (w_word),
    .i_wdata (DDT),
    .o_rdata (w_rdata),
    .o_be    (w_be),
    .o_wword (w_wword)
  );

  assign DDT = w_ddt_oe ? w_rdata : 'z;

  // A write caught by reset in its ACK cycle must not land
  always_ff @(posedge clk) begin
    if (!rst && w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i])
          r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for dmem_responder.
// Two instances: WAIT_STATES=1 (s=0) and WAIT_STATES=0 (s=1).
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  dmem_responder_if bus0();
  dmem_responder_if bus1();

  wire  [31:0] ddt0;
  wire  [31:0] ddt1;
  logic [31:0] wd0, wd1;
  logic        den0, den1;
  logic        err0, err1;

  assign ddt0 = den0 ? wd0 : 'z;
  assign ddt1 = den1 ? wd1 : 'z;

  dmem_responder #(.ADDR_BITS(12), .WAIT_STATES(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .DDT(ddt0), .misalign_err(err0)
  );

  dmem_responder #(.ADDR_BITS(12), .WAIT_STATES(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .DDT(ddt1), .misalign_err(err1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] mdl [int];
  logic        exp_err [2];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic ack(input int s);
    return (s != 0) ? bus1.ACKD_n : bus0.ACKD_n;
  endfunction

  function automatic logic oe(input int s);
    return (s != 0) ? dut1.w_ddt_oe : dut0.w_ddt_oe;
  endfunction

  function automatic logic [31:0] ddt(input int s);
    return (s != 0) ? ddt1 : ddt0;
  endfunction

  function automatic logic err(input int s);
    return (s != 0) ? err1 : err0;
  endfunction

  function automatic int key(input int s, input logic [31:0] a);
    return s * 4096 + int'((a >> 2) & 32'hFFF);
  endfunction

  // Reference: plain shifts and masks on a word-indexed memory
  function automatic logic [31:0] m_read(input int s,
      input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] w;
    w = mdl.exists(key(s, a)) ? mdl[key(s, a)] : 32'h0;
    if (sz == 2'b10) return (w >> ((a % 4) * 8)) & 32'hFF;
    if (sz == 2'b01) return (w >> ((a & 2) * 8)) & 32'hFFFF;
    return w;
  endfunction

  task automatic m_write(input int s, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w, m;
    int sh;
    w = mdl.exists(key(s, a)) ? mdl[key(s, a)] : 32'h0;
    if (sz == 2'b10) begin
      sh = int'(a % 4) * 8; m = 32'hFF << sh;
      w = (w & ~m) | ((d & 32'hFF) << sh);
    end else if (sz == 2'b01) begin
      sh = int'(a & 2) * 8; m = 32'hFFFF << sh;
      w = (w & ~m) | ((d & 32'hFFFF) << sh);
    end else begin
      w = d;
    end
    mdl[key(s, a)] = w;
  endtask

  function automatic logic m_mis(input logic [31:0] a,
                                 input logic [1:0] sz);
    if (sz == 2'b10) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  task automatic drive(input int s, input logic mreq,
      input logic wr, input logic [1:0] sz, input logic [31:0] a);
    if (s != 0) begin
      bus1.MREQ = mreq; bus1.WRITE = wr;
      bus1.SIZE = sz;   bus1.DAD = a;
    end else begin
      bus0.MREQ = mreq; bus0.WRITE = wr;
      bus0.SIZE = sz;   bus0.DAD = a;
    end
  endtask

  task automatic wdrv(input int s, input logic en,
                      input logic [31:0] d);
    if (s != 0) begin den1 = en; wd1 = d; end
    else        begin den0 = en; wd0 = d; end
  endtask

  task automatic txn(input int s, input logic wr,
      input logic [1:0] sz, input logic [31:0] a,
      input logic [31:0] d, output logic [31:0] rd);
    int ws, c0;
    logic got;
    ws  = (s != 0) ? 0 : 1;
    got = 1'b0;
    rd  = 32'h0;
    drive(s, 1'b1, wr, sz, a);
    if (wr) wdrv(s, 1'b1, d);
    exp_err[s] = exp_err[s] | m_mis(a, sz);
    c0 = cyc;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ack(s) == 1'b0) got = 1'b1;
      else chk("oe_wait", 32'(oe(s)), 32'd0);
    end
    chk("latency", 32'(cyc - c0), 32'(1 + ws));
    if (got) begin
      chk("oe_ack", 32'(oe(s)), 32'(!wr));
      if (!wr) rd = ddt(s);
    end
    chk("misalign", 32'(err(s)), 32'(exp_err[s]));
    @(posedge clk);
    #1;
    drive(s, 1'b0, 1'b0, SIZE_WORD, 32'h0);
    wdrv(s, 1'b0, 32'h0);
    if (wr) m_write(s, a, sz, d);
    tick();
    chk("ack_single", 32'(ack(s)), 32'd1);
    chk("oe_after", 32'(oe(s)), 32'd0);
  endtask

  task automatic burst(input int s, input logic [31:0] a,
                       input logic [31:0] exp);
    int ws, c0, last, n;
    ws = (s != 0) ? 0 : 1;
    n = 0; last = 0;
    drive(s, 1'b1, 1'b0, SIZE_WORD, a);
    c0 = cyc;
    for (int i = 0; i < 40 && n < 3; i++) begin
      tick();
      if (ack(s) == 1'b0) begin
        if (n == 0) chk("b_first", 32'(cyc - c0), 32'(1 + ws));
        else        chk("b_gap", 32'(cyc - last), 32'(2 + ws));
        chk("b_data", ddt(s), exp);
        last = cyc;
        n++;
        if (n == 3) drive(s, 1'b0, 1'b0, SIZE_WORD, a);
      end
    end
    chk("b_count", 32'(n), 32'd3);
    tick();
    chk("b_idle", 32'(ack(s)), 32'd1);
  endtask

  logic [31:0] rd, a, d;
  logic [1:0]  sz;
  logic        wr;

  initial begin
    rst = 1'b1;
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;
    wdrv(0, 1'b0, 32'h0);
    wdrv(1, 1'b0, 32'h0);
    drive(0, 1'b0, 1'b0, SIZE_WORD, 32'h0);
    drive(1, 1'b0, 1'b0, SIZE_WORD, 32'h0);
    tick(); tick();
    chk("rst_ack0", 32'(ack(0)), 32'd1);
    chk("rst_ack1", 32'(ack(1)), 32'd1);
    chk("rst_oe0", 32'(oe(0)), 32'd0);
    chk("rst_err0", 32'(err(0)), 32'd0);
    rst = 1'b0;
    tick();

    txn(0, 1'b1, SIZE_WORD, 32'h100, 32'hDEADBEEF, rd);
    txn(0, 1'b0, SIZE_WORD, 32'h100, 32'h0, rd);
    chk("rd_word", rd, 32'hDEADBEEF);

    txn(0, 1'b1, SIZE_WORD, 32'h100, 32'h11223344, rd);
    txn(0, 1'b1, SIZE_BYTE, 32'h101, 32'hFFFFFFAA, rd);
    txn(0, 1'b0, SIZE_WORD, 32'h100, 32'h0, rd);
    chk("rd_merge", rd, 32'h1122AA44);
    txn(0, 1'b0, SIZE_BYTE, 32'h101, 32'h0, rd);
    chk("rd_byte", rd, 32'h000000AA);
    txn(0, 1'b0, SIZE_HALF, 32'h102, 32'h0, rd);
    chk("rd_half", rd, 32'h00001122);

    burst(0, 32'h100, 32'h1122AA44);
    txn(1, 1'b1, SIZE_WORD, 32'h40, 32'hCAFEF00D, rd);
    burst(1, 32'h40, 32'hCAFEF00D);

    txn(0, 1'b0, SIZE_WORD, 32'h103, 32'h0, rd);
    chk("rd_misal", rd, 32'h1122AA44);
    txn(0, 1'b0, SIZE_BYTE, 32'h100, 32'h0, rd);
    chk("rd_byte0", rd, 32'h00000044);
    chk("err_sticky", 32'(err(0)), 32'd1);

    txn(0, 1'b1, SIZE_WORD, 32'h4100, 32'h5A5A1234, rd);
    txn(0, 1'b0, SIZE_WORD, 32'h100, 32'h0, rd);
    chk("rd_wrap", rd, 32'h5A5A1234);

    txn(0, 1'b1, SIZE_WORD, 32'h200, 32'h0BADF00D, rd);
    drive(0, 1'b1, 1'b1, SIZE_WORD, 32'h200);
    wdrv(0, 1'b1, 32'h77777777);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_ack", 32'(ack(0)), 32'd1);
    chk("rst_mid_oe", 32'(oe(0)), 32'd0);
    chk("rst_clr_err", 32'(err(0)), 32'd0);
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, SIZE_WORD, 32'h0);
    wdrv(0, 1'b0, 32'h0);
    rst = 1'b0;
    tick();
    txn(0, 1'b0, SIZE_WORD, 32'h200, 32'h0, rd);
    chk("rd_old", rd, 32'h0BADF00D);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        txn(s, 1'b1, SIZE_WORD, 32'h300 + 32'(4 * i),
            $urandom, rd);
      end
      for (int i = 0; i < 40; i++) begin
        wr = 1'(($urandom >> 3) & 1);
        sz = 2'($urandom_range(0, 3));
        a  = 32'h300 + 32'($urandom_range(0, 63));
        d  = $urandom;
        txn(s, wr, sz, a, d, rd);
        if (!wr) chk("rnd_rd", rd, m_read(s, a, sz));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
